// File: rtl/uart_rx_os_if.sv
// Received-word handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_os_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_parity_err;
  logic                  m_frame_err;

  modport master (
    output m_data, m_valid, m_parity_err, m_frame_err,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_parity_err, m_frame_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF sync, 3-sample majority vote, parity/framing checks,
// false-start rejection and a valid/ready output with overrun detection.
module uart_rx_os #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         rxd,
  uart_rx_os_if.master m,
  output logic         overrun_err,
  output logic         busy
);
  localparam int unsigned TickDivRaw = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TickDiv    = (TickDivRaw < 1) ? 1 : TickDivRaw;
  localparam int unsigned TickW      = $clog2(TickDiv) + 1;
  localparam int unsigned SampW      = $clog2(OVERSAMPLE);
  localparam int unsigned BitW       = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned Mid        = OVERSAMPLE / 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e                state_q;
  logic                  sync0_q, rxs_q, rxs_prev_q;
  logic [TickW-1:0]      tick_cnt_q;
  logic [SampW-1:0]      samp_cnt_q;
  logic [BitW-1:0]       bit_idx_q;
  logic                  stop_idx_q;
  logic                  vote_a_q, vote_b_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  perr_q, ferr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, data_perr_q, data_ferr_q;
  logic                  overrun_q, busy_q;

  logic tick, start_det, sample_a, sample_b, decide, bit_end, vote;

  assign tick      = (tick_cnt_q == TickW'(TickDiv - 1));
  assign start_det = (state_q == StIdle) && rxs_prev_q && !rxs_q;
  assign sample_a  = tick && (samp_cnt_q == SampW'(Mid - 1));
  assign sample_b  = tick && (samp_cnt_q == SampW'(Mid));
  assign decide    = tick && (samp_cnt_q == SampW'(Mid + 1));
  assign bit_end   = tick && (samp_cnt_q == SampW'(OVERSAMPLE - 1));
  assign vote      = (vote_a_q & vote_b_q) | (vote_a_q & rxs_q) | (vote_b_q & rxs_q);

  assign m.m_data       = data_q;
  assign m.m_valid      = valid_q;
  assign m.m_parity_err = data_perr_q;
  assign m.m_frame_err  = data_ferr_q;
  assign overrun_err    = overrun_q;
  assign busy           = busy_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync0_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync0_q    <= rxd;
      rxs_q      <= sync0_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Restarting on start detection aligns the tick phase to the falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
    end else if (start_det || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      samp_cnt_q  <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      vote_a_q    <= 1'b1;
      vote_b_q    <= 1'b1;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      data_perr_q <= 1'b0;
      data_ferr_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && m.m_ready) valid_q <= 1'b0;
      if (tick) samp_cnt_q <= bit_end ? '0 : samp_cnt_q + 1'b1;
      if (sample_a) vote_a_q <= rxs_q;
      if (sample_b) vote_b_q <= rxs_q;

      unique case (state_q)
        StIdle: begin
          if (start_det) begin
            state_q    <= StStart;
            samp_cnt_q <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StStart: begin
          if (decide && vote) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q   <= StData;
            bit_idx_q <= '0;
          end
        end
        StData: begin
          if (decide) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (bit_idx_q == BitW'(i)) shift_q[i] <= vote;
            end
          end
          if (bit_end) begin
            if (bit_idx_q == BitW'(DATA_WIDTH - 1)) begin
              state_q    <= (PARITY != 0) ? StParity : StStop;
              stop_idx_q <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        StParity: begin
          // Odd mode expects the XOR over data and parity to be 1, even mode 0.
          if (decide) perr_q <= (^shift_q) ^ vote ^ (PARITY == 1);
          if (bit_end) begin
            state_q    <= StStop;
            stop_idx_q <= 1'b0;
          end
        end
        StStop: begin
          if (decide) begin
            if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              if (!valid_q || m.m_ready) begin
                data_q      <= shift_q;
                data_perr_q <= perr_q;
                data_ferr_q <= ferr_q | ~vote;
                valid_q     <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= rxs_q ? StIdle : StBreak;
              busy_q  <= !rxs_q;
            end else begin
              ferr_q <= ferr_q | ~vote;
            end
          end
          if (bit_end) stop_idx_q <= 1'b1;
        end
        StBreak: begin
          if (rxs_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
